// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver feeding a one-byte valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    input  logic       i_RX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Frame_Err,
    output logic       o_Overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, CLEANUP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, CLEANUP
    } state_t;
`endif

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          dv_q, dv_d;
    logic [7:0]    byte_q, byte_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;
    logic          done;
    logic          bad;
    logic          accept;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign rx_s = sync2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        done       = 1'b0;
        bad        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                // Only a genuinely sampled high line (not reset values) arms start detection
                if (sync_vld_q[1] && rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d             = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
`ifdef UART_RX_PARITY_EN
                    if (rx_s && !(^{shift_q, par_q})) begin
`else
                    if (rx_s) begin
`endif
                        done = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A completion is dropped only if the held byte is not leaving this clock
    always_comb begin
        accept = dv_q && i_RX_Ready;
        dv_d   = dv_q;
        byte_d = byte_q;
        ovr_d  = 1'b0;
        ferr_d = bad;
        if (accept) begin
            dv_d = 1'b0;
        end
        if (done) begin
            if (!dv_q || accept) begin
                dv_d   = 1'b1;
                byte_d = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync_vld_q <= '0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            dv_q       <= 1'b0;
            byte_q     <= 8'h00;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= i_RX_Serial;
            sync2_q    <= sync1_q;
            sync_vld_q <= sync_vld_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_Frame_Err = ferr_q;
    assign o_Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: table-driven, directed and randomized frames
// checked against a frame-level model of the receiver.
module tb_uart_rx_buffered;

    localparam int C    = 217;
    localparam int HALF = (C - 1) / 2;
    // Clock edges from the line falling to DV rising: 2 sync + 1 detect,
    // half-bit start check, 8 data bits, (parity,) stop bit.
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + HALF + 1 + 10 * C;
`else
    localparam int LAT = 3 + HALF + 1 + 9 * C;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rdy = 1'b0;
    logic       dv;
    logic [7:0] rbyte;
    logic       ferr;
    logic       ovr;

    uart_rx_buffered #(.CLKS_PER_BIT(C)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_RX_Serial(rx),
        .i_RX_Ready (rdy),
        .o_RX_DV    (dv),
        .o_RX_Byte  (rbyte),
        .o_Frame_Err(ferr),
        .o_Overrun  (ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int         n_ferr   = 0;
    int         n_ovr    = 0;
    int         n_rise   = 0;
    int         rise_cyc = -1;
    int         n_acc    = 0;
    int         stab_bad = 0;
    logic [7:0] last_acc = 8'h00;
    logic       dv_p     = 1'b0;
    logic       acc_p    = 1'b0;
    logic [7:0] byte_p   = 8'h00;

    always @(negedge clk) begin
        if (ferr) n_ferr <= n_ferr + 1;
        if (ovr) n_ovr <= n_ovr + 1;
        if (dv && !dv_p) begin
            n_rise   <= n_rise + 1;
            rise_cyc <= cyc;
        end
        if (dv && rdy) begin
            n_acc    <= n_acc + 1;
            last_acc <= rbyte;
        end
        if (!rst && dv && dv_p && !acc_p && rbyte != byte_p)
            stab_bad <= stab_bad + 1;
        dv_p   <= dv;
        acc_p  <= dv && rdy;
        byte_p <= rbyte;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clk(C);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic par);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    task automatic take;
        rdy = 1'b1;
        wait_clk(1);
        rdy = 1'b0;
        chk("dv_falls_on_accept", dv, 1'b0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_dv;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int f0, r0, o0, a0;

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 1};
        vecs[5] = '{8'hAA, 1'b1, 1'b1, 0};

        wait_clk(3);
        chk("reset_dv", dv, 1'b0);
        chk("reset_byte", rbyte, 8'h00);
        chk("reset_ferr", ferr, 1'b0);
        chk("reset_ovr", ovr, 1'b0);
        rst = 1'b0;
        wait_clk(10);

        // Byte held with ready low, exact DV latency
        r0 = n_rise;
        send(8'h3F, 1'b1);
        chk("3f_rise_cycle", rise_cyc, t0 + LAT);
        chk("3f_rise_count", n_rise - r0, 1);
        chk("3f_dv", dv, 1'b1);
        chk("3f_byte", rbyte, 8'h3F);
        wait_clk(500);
        chk("3f_dv_held", dv, 1'b1);
        chk("3f_byte_held", rbyte, 8'h3F);
        take();

        for (int i = 0; i < 6; i++) begin
            f0 = n_ferr;
            send(vecs[i].d, vecs[i].stop);
            wait_clk(20);
            chk($sformatf("vec%0d_dv", i), dv, vecs[i].exp_dv);
            if (vecs[i].exp_dv) chk($sformatf("vec%0d_byte", i), rbyte, vecs[i].d);
            chk($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            wait_clk(200);
            if (dv) take();
        end

        // Short low glitch on an idle line
        r0 = n_rise;
        f0 = n_ferr;
        rx = 1'b0;
        wait_clk(100);
        rx = 1'b1;
        wait_clk(300);
        chk("glitch_no_dv", n_rise - r0, 0);
        chk("glitch_no_ferr", n_ferr - f0, 0);
        send(8'hA5, 1'b1);
        wait_clk(5);
        chk("a5_dv", dv, 1'b1);
        chk("a5_byte", rbyte, 8'hA5);
        take();

        // Overrun, then completion coinciding with acceptance
        send(8'h11, 1'b1);
        wait_clk(5);
        chk("11_byte", rbyte, 8'h11);
        o0 = n_ovr;
        send(8'h22, 1'b1);
        wait_clk(5);
        chk("22_overrun", n_ovr - o0, 1);
        chk("22_byte_kept", rbyte, 8'h11);
        chk("22_dv", dv, 1'b1);
        r0 = n_rise;
        o0 = n_ovr;
        a0 = n_acc;
        fork
            send(8'h33, 1'b1);
            begin
                wait_clk(LAT - 1);
                rdy = 1'b1;
                wait_clk(1);
                rdy = 1'b0;
            end
        join
        chk("33_byte", rbyte, 8'h33);
        chk("33_dv", dv, 1'b1);
        chk("33_no_drop", n_rise - r0, 0);
        chk("33_no_overrun", n_ovr - o0, 0);
        chk("33_accepted_11", last_acc, 8'h11);
        chk("33_accept_count", n_acc - a0, 1);
        take();

        // Reset during bit 4 of 0xC3 with a byte held
        send(8'h5A, 1'b1);
        wait_clk(5);
        chk("5a_dv", dv, 1'b1);
        fork
            send(8'hC3, 1'b1);
            begin
                wait_clk(5 * C + C / 2);
                rst = 1'b1;
                wait_clk(1);
                chk("rst_dv", dv, 1'b0);
                chk("rst_byte", rbyte, 8'h00);
                chk("rst_ferr", ferr, 1'b0);
                chk("rst_ovr", ovr, 1'b0);
                rst = 1'b0;
                r0 = n_rise;
                f0 = n_ferr;
            end
        join
        wait_clk(300);
        chk("c3_abandoned_dv", n_rise - r0, 0);
        chk("c3_abandoned_ferr", n_ferr - f0, 0);
        send(8'h81, 1'b1);
        wait_clk(5);
        chk("81_dv", dv, 1'b1);
        chk("81_byte", rbyte, 8'h81);
        take();

`ifdef UART_RX_PARITY_EN
        f0 = n_ferr;
        r0 = n_rise;
        send_par(8'h07, 1'b0);
        wait_clk(20);
        chk("par0_ferr", n_ferr - f0, 1);
        chk("par0_no_dv", n_rise - r0, 0);
        wait_clk(200);
        send_par(8'h07, 1'b1);
        wait_clk(5);
        chk("par1_dv", dv, 1'b1);
        chk("par1_byte", rbyte, 8'h07);
        take();
`endif

        // Random frames, consumer always ready
        rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       stop;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            a0   = n_acc;
            f0   = n_ferr;
            o0   = n_ovr;
            send(d, stop);
            wait_clk(20 + $urandom_range(0, 50));
            chk($sformatf("rnd%0d_accepts", i), n_acc - a0, stop ? 1 : 0);
            if (stop) chk($sformatf("rnd%0d_byte", i), last_acc, d);
            chk($sformatf("rnd%0d_ferr", i), n_ferr - f0, stop ? 0 : 1);
            chk($sformatf("rnd%0d_ovr", i), n_ovr - o0, 0);
            if (!stop) wait_clk(150);
        end
        rdy = 1'b0;

        chk("byte_stable_while_held", stab_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
